// File: rtl/uart_frame_codec_if.sv
// uart_frame_codec_if
// Groups the serial lines, the RX frame-write port and the TX byte port of
// uart_frame_codec. clk and rst stay plain ports on the codec.
//
// Signals:
//   baud_div     clocks per bit (4 or more), sampled at each start bit
//   rxd / txd    serial in (asynchronous, idles high) / serial out (idles high)
//   wr_en        one-cycle pulse when a full RX frame is assembled
//   wr_data      assembled frame, byte k in bits [8k+7:8k]
//   frame_err    one-cycle pulse on a stop-bit or parity error
//   rx_err_cnt   saturating count of errors plus timeouts
//   out_en       TX byte write strobe (valid)
//   out_data     TX byte
//   out_free     TX FIFO not full (ready)
//   tx_busy      TX FIFO non-empty or a byte on the line
//   rx_state_dbg / tx_state_dbg   current FSM states, for observation only
//
// TX handshake: a byte transfers on a clock edge where out_en and out_free
// are both high; out_en while out_free is low is discarded, not held.
//
// Modports: master = host side driving the codec, slave = the codec.
interface uart_frame_codec_if #(
  parameter int FRAME_BYTES = 36,
  parameter int DIV_W       = 16
);
  logic [DIV_W-1:0]         baud_div;
  logic                     rxd;
  logic                     txd;
  logic                     wr_en;
  logic [8*FRAME_BYTES-1:0] wr_data;
  logic                     frame_err;
  logic [7:0]               rx_err_cnt;
  logic                     out_en;
  logic [7:0]               out_data;
  logic                     out_free;
  logic                     tx_busy;
  logic [2:0]               rx_state_dbg;
  logic [2:0]               tx_state_dbg;

  modport master (
    output baud_div, rxd, out_en, out_data,
    input  txd, wr_en, wr_data, frame_err, rx_err_cnt, out_free, tx_busy,
           rx_state_dbg, tx_state_dbg
  );

  modport slave (
    input  baud_div, rxd, out_en, out_data,
    output txd, wr_en, wr_data, frame_err, rx_err_cnt, out_free, tx_busy,
           rx_state_dbg, tx_state_dbg
  );
endinterface

// File: rtl/uart_frame_codec.sv
// uart_frame_codec
// UART codec for the accelerator host link. RX deserialises bytes and packs
// FRAME_BYTES of them into one wide word pulsed out on wr_en. TX queues bytes
// in a TX_DEPTH FIFO and sends them back to back. Runtime baud divisor,
// optional parity (0 none, 1 odd, 2 even), stop/parity error detection and a
// partial-frame timeout of TIMEOUT_BITS bit-times.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_frame_codec_if.slave (serial lines, frame port, TX byte port)
module uart_frame_codec #(
  parameter int FRAME_BYTES  = 36,
  parameter int DIV_W        = 16,
  parameter int TX_DEPTH     = 16,
  parameter int PARITY       = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input logic              clk,
  input logic              rst,
  uart_frame_codec_if.slave bus
);

  localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = DIV_W + $clog2(TIMEOUT_BITS + 1);
  localparam int WD_W  = 8 * FRAME_BYTES;

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(TX_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BYTES - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  // ---------------------------------------------------------------- RX ----
  logic             rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_par_bad_q, rx_par_bad_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]  to_limit;
  logic [WD_W-1:0]  wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             rx_tick, start_seen, err_inc;

  assign to_limit = TO_W'(TIMEOUT_BITS) * {{(TO_W-DIV_W){1'b0}}, rx_div_q};

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_idx_d     = rx_idx_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_err_d  = 1'b0;
    err_inc      = 1'b0;
    start_seen   = 1'b0;
    rx_tick      = (rx_cnt_q == rx_div_q - DIV_ONE);

    case (rx_state_q)
      RX_IDLE: begin
        // A falling edge needs the line seen high first, so after a stop-bit
        // error with the line held low the FSM re-arms only once it rises.
        if (rxd_prev_q && !rxd_s2_q) begin
          start_seen = 1'b1;
          rx_div_d   = bus.baud_div;
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1) - DIV_ONE) begin
          rx_cnt_d = '0;
          if (rxd_s2_q) begin
            rx_state_d = RX_IDLE;       // glitch, not a start bit
          end else begin
            rx_bit_d     = '0;
            rx_par_bad_d = 1'b0;
            rx_state_d   = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_ONE;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_ONE;
        end
      end
      RX_PAR: begin
        if (rx_tick) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = ((^rx_shift_q) ^ rxd_s2_q) != PAR_ODD;
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_ONE;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rxd_s2_q || rx_par_bad_q) begin
            frame_err_d = 1'b1;
            err_inc     = 1'b1;
            rx_idx_d    = '0;
          end else begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
              if (rx_idx_q == IDX_W'(k)) wr_data_d[8*k +: 8] = rx_shift_q;
            end
            if (rx_idx_q == IDX_LAST) begin
              wr_en_d  = 1'b1;
              rx_idx_d = '0;
            end else begin
              rx_idx_d = rx_idx_q + IDX_W'(1);
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + DIV_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Timeout only acts while idle, so it never races a stop-bit decision.
    if (rx_state_q == RX_IDLE && !start_seen && rx_idx_q != '0 &&
        to_cnt_q >= to_limit) begin
      rx_idx_d = '0;
      err_inc  = 1'b1;
    end

    // Counts clocks since the last start edge while a frame is partial.
    if (rx_idx_d == '0 || start_seen) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < to_limit) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      rxd_prev_q   <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= DIV_W'(4);
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      rx_idx_q     <= '0;
      to_cnt_q     <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      rxd_s1_q     <= bus.rxd;
      rxd_s2_q     <= rxd_s1_q;
      rxd_prev_q   <= rxd_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_idx_q     <= rx_idx_d;
      to_cnt_q     <= to_cnt_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------- TX ----
  // The byte on the line keeps its FIFO slot until its stop bit ends, so
  // out_free reflects the in-flight byte as well as the queued ones.
  logic [7:0]       mem_q [TX_DEPTH];
  logic [7:0]       mem_d [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             push, tx_pop, tx_load;
  logic [PTR_W-1:0] tx_load_ptr;

  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_par_q, tx_par_d;
  logic             txd_q, txd_d;
  logic             tx_tick;

  assign push = bus.out_en && (fifo_cnt_q != FIFO_FULL);

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.out_data;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = tx_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !tx_pop) fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    if (!push && tx_pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_pop      = 1'b0;
    tx_load     = 1'b0;
    tx_load_ptr = rd_ptr_q;
    tx_tick     = (tx_cnt_q == tx_div_q - DIV_ONE);

    case (tx_state_q)
      TX_IDLE: begin
        if (fifo_cnt_q != '0) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_ONE;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_ONE;
        end
      end
      TX_PAR: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_ONE;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          tx_pop   = 1'b1;
          if (fifo_cnt_q > CNT_W'(1)) begin
            tx_load     = 1'b1;          // next byte follows with no gap
            tx_load_ptr = rd_ptr_q + PTR_ONE;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d = mem_q[tx_load_ptr];
      tx_par_d   = (^mem_q[tx_load_ptr]) ^ PAR_ODD;
      tx_div_d   = bus.baud_div;
      tx_cnt_d   = '0;
      tx_state_d = TX_START;
    end

    // txd is registered alongside the state so it always matches it.
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      TX_PAR:   txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(4);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  // ----------------------------------------------------------- outputs ----
  assign bus.txd          = txd_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.rx_err_cnt   = err_cnt_q;
  assign bus.out_free     = (fifo_cnt_q != FIFO_FULL);
  assign bus.tx_busy      = (fifo_cnt_q != '0) || (tx_state_q != TX_IDLE);
  assign bus.rx_state_dbg = rx_state_q;
  assign bus.tx_state_dbg = tx_state_q;

endmodule

// File: tb/tb_uart_frame_codec.sv
module tb_uart_frame_codec;

  // ---- clock / reset ----
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = 16'd8;
  logic        rxd = 1'b1;
  logic        out_en = 1'b0;
  logic [7:0]  out_data = 8'h00;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: no parity, dut1: even parity; both see the same stimulus
  uart_frame_codec_if #(.FRAME_BYTES(4), .DIV_W(16)) if0 ();
  uart_frame_codec_if #(.FRAME_BYTES(4), .DIV_W(16)) if1 ();

  assign if0.baud_div = div;
  assign if0.rxd      = rxd;
  assign if0.out_en   = out_en;
  assign if0.out_data = out_data;
  assign if1.baud_div = div;
  assign if1.rxd      = rxd;
  assign if1.out_en   = out_en;
  assign if1.out_data = out_data;

  uart_frame_codec #(.FRAME_BYTES(4), .DIV_W(16), .TX_DEPTH(4), .PARITY(0),
                     .TIMEOUT_BITS(20)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  uart_frame_codec #(.FRAME_BYTES(4), .DIV_W(16), .TX_DEPTH(4), .PARITY(2),
                     .TIMEOUT_BITS(20)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // ---- pulse monitors ----
  int          wr_n0 = 0, wr_n1 = 0, fe_n0 = 0, fe_n1 = 0;
  logic [31:0] wr_last0 = '0, wr_last1 = '0;

  always @(negedge clk) begin
    if (if0.wr_en) begin wr_n0++; wr_last0 = if0.wr_data; end
    if (if1.wr_en) begin wr_n1++; wr_last1 = if1.wr_data; end
    if (if0.frame_err) fe_n0++;
    if (if1.frame_err) fe_n1++;
  end

  // ---- scoreboard helper ----
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rxd = 1'b1; out_en = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(3);
  endtask

  // start, 8 data LSB first, optional parity, stop, then one idle bit
  task automatic send_byte(input logic [7:0] d, input logic has_par,
                           input logic par, input logic stop_b);
    int n;
    n = int'(div);
    rxd = 1'b0; idle(n);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; idle(n); end
    if (has_par) begin rxd = par; idle(n); end
    rxd = stop_b; idle(n);
    rxd = 1'b1; idle(n);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b0, 1'b1);
  endtask

  int          base_wr, base_fe;
  logic [39:0] stream;
  logic [10:0] pbits;
  logic [7:0]  b;

  initial begin
    // ---- reset state ----
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("rst_txd", if0.txd, 1);
    chk("rst_wr_en", if0.wr_en, 0);
    chk("rst_wr_data", if0.wr_data, 0);
    chk("rst_frame_err", if0.frame_err, 0);
    chk("rst_err_cnt", if0.rx_err_cnt, 0);
    chk("rst_out_free", if0.out_free, 1);
    chk("rst_tx_busy", if0.tx_busy, 0);

    // ---- RX basic frame ----
    div = 16'd8;
    base_wr = wr_n0; base_fe = fe_n0;
    send_good(8'h11); send_good(8'h22); send_good(8'h33); send_good(8'h44);
    idle(16);
    chk("t1_wr_pulses", wr_n0 - base_wr, 1);
    chk("t1_wr_data", wr_last0, 32'h44332211);
    chk("t1_frame_err", fe_n0 - base_fe, 0);
    chk("t1_err_cnt", if0.rx_err_cnt, 0);

    // ---- stop-bit error drops partial frame ----
    do_reset();
    base_wr = wr_n0; base_fe = fe_n0;
    send_good(8'hEE);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    send_good(8'hA0); send_good(8'hA1); send_good(8'hA2); send_good(8'hA3);
    idle(16);
    chk("t2_frame_err", fe_n0 - base_fe, 1);
    chk("t2_err_cnt", if0.rx_err_cnt, 1);
    chk("t2_wr_pulses", wr_n0 - base_wr, 1);
    chk("t2_wr_data", wr_last0, 32'hA3A2A1A0);

    // ---- partial-frame timeout ----
    do_reset();
    base_wr = wr_n0; base_fe = fe_n0;
    send_good(8'hBB); send_good(8'hCC);
    idle(200);
    chk("t3_err_after_idle", if0.rx_err_cnt, 1);
    send_good(8'h01); send_good(8'h02); send_good(8'h03); send_good(8'h04);
    idle(16);
    chk("t3_wr_pulses", wr_n0 - base_wr, 1);
    chk("t3_wr_data", wr_last0, 32'h04030201);
    chk("t3_frame_err", fe_n0 - base_fe, 0);
    chk("t3_err_cnt", if0.rx_err_cnt, 1);

    // ---- even parity RX ----
    do_reset();
    base_wr = wr_n1; base_fe = fe_n1;
    send_byte(8'h07, 1'b1, 1'b1, 1'b1);
    send_byte(8'h81, 1'b1, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t4_wr_pulses", wr_n1 - base_wr, 1);
    chk("t4_wr_data", wr_last1, 32'hFF008107);
    chk("t4_no_frame_err", fe_n1 - base_fe, 0);
    chk("t4_err_cnt0", if1.rx_err_cnt, 0);
    send_byte(8'h07, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t4_par_frame_err", fe_n1 - base_fe, 1);
    chk("t4_par_err_cnt", if1.rx_err_cnt, 1);

    // ---- even parity TX of 0x07: start, 11100000, parity 1, stop ----
    do_reset();
    pbits = {1'b1, 1'b1, 8'h07, 1'b0};
    out_data = 8'h07; out_en = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 1) out_en = 1'b0;
      if (k >= 6 && k <= 86 && ((k - 6) % 8) == 0)
        chk($sformatf("t4_tx_bit%0d", (k - 6) / 8), if1.txd, pbits[(k - 6) / 8]);
    end
    chk("t4_tx_busy_end", if1.tx_busy, 0);

    // ---- TX FIFO back-pressure and back-to-back bytes ----
    do_reset();
    div = 16'd4;
    for (int j = 0; j < 4; j++) begin
      b = 8'h10 + 8'(j);
      stream[10*j +: 10] = {1'b1, b, 1'b0};
    end
    out_data = 8'h10; out_en = 1'b1;
    for (int k = 1; k <= 165; k++) begin
      @(negedge clk);
      if (k <= 6) chk($sformatf("t5_out_free_k%0d", k), if0.out_free, (k <= 3));
      chk($sformatf("t5_txd_k%0d", k), if0.txd,
          (k < 2 || k >= 162) ? 1'b1 : stream[(k - 2) / 4]);
      chk($sformatf("t5_busy_k%0d", k), if0.tx_busy, (k <= 161));
      if (k <= 5) out_data = 8'h10 + 8'(k);
      else out_en = 1'b0;
    end

    // ---- reset mid-TX byte and mid-RX frame ----
    do_reset();
    div = 16'd8;
    send_good(8'hE1); send_good(8'hE2);
    out_data = 8'h00; out_en = 1'b1;
    idle(1);
    out_en = 1'b0;
    rxd = 1'b0; idle(8);
    rxd = 1'b1; idle(8);
    rxd = 1'b0; idle(4);
    chk("t6_txd_before_rst", if0.txd, 0);
    rst = 1'b1;
    idle(1);
    chk("t6_txd_after_rst", if0.txd, 1);
    chk("t6_wr_en_rst", if0.wr_en, 0);
    chk("t6_busy_rst", if0.tx_busy, 0);
    chk("t6_free_rst", if0.out_free, 1);
    rst = 1'b0; rxd = 1'b1;
    idle(20);
    chk("t6_txd_idle", if0.txd, 1);
    base_wr = wr_n0; base_fe = fe_n0;
    send_good(8'hC1); send_good(8'hC2); send_good(8'hC3); send_good(8'hC4);
    idle(16);
    chk("t6_wr_pulses", wr_n0 - base_wr, 1);
    chk("t6_wr_data", wr_last0, 32'hC4C3C2C1);
    chk("t6_frame_err", fe_n0 - base_fe, 0);

    // ---- error counter saturation ----
    do_reset();
    div = 16'd4;
    base_fe = fe_n0;
    for (int i = 0; i < 255; i++) send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("t7_err_cnt_255", if0.rx_err_cnt, 255);
    send_byte(8'h00, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("t7_err_cnt_hold", if0.rx_err_cnt, 255);
    chk("t7_frame_err_pulses", fe_n0 - base_fe, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
